// File: rtl/arb_requester_if.sv
// Requester-side bundle between a job source, the arbiter and arb_requester.
// The slave modport is the requester's view; the master modport is the view
// of the environment that offers jobs and returns the grant.
interface arb_requester_if #(
   parameter int LEN_W = 4
) ();

   logic             job_valid;
   logic [LEN_W-1:0] job_len;
   logic             job_ready;
   logic             r;
   logic             g;
   logic             xfer;
   logic [LEN_W-1:0] beat_cnt;
   logic             done;
   logic             timeout_err;
   logic             abort_err;
   logic             busy;

   modport master (
      output job_valid, job_len, g,
      input  job_ready, r, xfer, beat_cnt, done, timeout_err, abort_err, busy
   );

   modport slave (
      input  job_valid, job_len, g,
      output job_ready, r, xfer, beat_cnt, done, timeout_err, abort_err, busy
   );

endinterface

// File: rtl/arb_requester.sv
// Requester agent for the 3-way grant arbiter: takes a burst job, requests
// the bus, counts beats while granted, then holds the request low for a
// release gap until the arbiter's registered grant has fallen.
module arb_requester #(
   parameter int LEN_W   = 4,
   parameter int TIMEOUT = 16,
   parameter int GAP     = 1
) (
   input  logic           Clock,
   input  logic           Resetn,
   arb_requester_if.slave bus
);

   localparam int WAIT_W = $clog2(TIMEOUT);
   localparam int GAP_W  = $clog2(GAP + 1) + 1;
   localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);
   localparam logic [GAP_W-1:0]  GAP_MIN   = GAP_W'(GAP);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      REQ     = 2'd1,
      XFER    = 2'd2,
      RELEASE = 2'd3
   } state_t;

   state_t            state_q, state_d;
   logic [LEN_W-1:0]  len_q, len_d;
   logic [LEN_W-1:0]  beat_q, beat_d;
   logic [WAIT_W-1:0] wait_q, wait_d;
   logic [GAP_W-1:0]  gap_q, gap_d;
   logic              done_q, done_d;
   logic              timeout_q, timeout_d;
   logic              abort_q, abort_d;
   logic [GAP_W-1:0]  gap_inc;

   // The gap counter saturates at GAP, so one extra bit is enough headroom
   // for the incremented value used in the exit test.
   assign gap_inc = gap_q + 1'b1;

   // State and counter registers; reset abandons any burst silently.
   always_ff @(posedge Clock) begin
      if (!Resetn) begin
         state_q   <= IDLE;
         len_q     <= '0;
         beat_q    <= '0;
         wait_q    <= '0;
         gap_q     <= '0;
         done_q    <= 1'b0;
         timeout_q <= 1'b0;
         abort_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         len_q     <= len_d;
         beat_q    <= beat_d;
         wait_q    <= wait_d;
         gap_q     <= gap_d;
         done_q    <= done_d;
         timeout_q <= timeout_d;
         abort_q   <= abort_d;
      end
   end

   // Next-state logic; the three status flags are one-cycle pulses and each
   // is raised only on the single transition into RELEASE that caused it.
   always_comb begin
      state_d   = state_q;
      len_d     = len_q;
      beat_d    = beat_q;
      wait_d    = wait_q;
      gap_d     = gap_q;
      done_d    = 1'b0;
      timeout_d = 1'b0;
      abort_d   = 1'b0;

      case (state_q)
         IDLE: begin
            if (bus.job_valid) begin
               len_d  = bus.job_len;
               beat_d = '0;
               wait_d = '0;
               if (bus.job_len != '0) begin
                  state_d = REQ;
               end else begin
                  done_d  = 1'b1;
                  gap_d   = '0;
                  state_d = RELEASE;
               end
            end
         end

         REQ: begin
            if (bus.g) begin
               state_d = XFER;
            end else if (wait_q == WAIT_LAST) begin
               timeout_d = 1'b1;
               gap_d     = '0;
               state_d   = RELEASE;
            end else begin
               wait_d = wait_q + 1'b1;
            end
         end

         XFER: begin
            if (bus.g) begin
               beat_d = beat_q + 1'b1;
               if (beat_q == len_q - 1'b1) begin
                  done_d  = 1'b1;
                  gap_d   = '0;
                  state_d = RELEASE;
               end
            end else begin
               abort_d = 1'b1;
               gap_d   = '0;
               state_d = RELEASE;
            end
         end

         RELEASE: begin
            if (gap_q < GAP_MIN) begin
               gap_d = gap_inc;
            end
            if ((gap_inc >= GAP_MIN) && !bus.g) begin
               state_d = IDLE;
            end
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign bus.r           = (state_q == REQ) || (state_q == XFER);
   assign bus.job_ready   = (state_q == IDLE);
   assign bus.busy        = (state_q != IDLE);
   assign bus.xfer        = (state_q == XFER) && bus.g;
   assign bus.beat_cnt    = beat_q;
   assign bus.done        = done_q;
   assign bus.timeout_err = timeout_q;
   assign bus.abort_err   = abort_q;

endmodule

// File: tb/tb_arb_requester.sv
// Testbench for arb_requester. Each job is described by its length and the
// grant pattern the bench will play back (grant delay after r rises, beats
// granted, extra grant cycles after the burst). The expected outcome is
// worked out from those numbers and queued; a negedge monitor pops it when
// the DUT raises done/timeout_err/abort_err.
module tb_arb_requester;

   localparam int LEN_W   = 4;
   localparam int TIMEOUT = 16;
   localparam int GAP     = 1;

   typedef struct {
      int kind;
      int beats;
      int cycle;
      int rHigh;
      int relLen;
   } exp_t;

   logic Clock  = 1'b0;
   logic Resetn = 1'b0;
   int   cyc    = 0;
   int   checks = 0;
   int   errors = 0;
   exp_t expQ[$];

   int rCount    = 0;
   int xferCount = 0;
   int relCount  = 0;
   int relExp    = 0;
   bit inRelease = 1'b0;

   arb_requester_if #(.LEN_W(LEN_W)) bus ();

   arb_requester #(
      .LEN_W  (LEN_W),
      .TIMEOUT(TIMEOUT),
      .GAP    (GAP)
   ) dut (
      .Clock (Clock),
      .Resetn(Resetn),
      .bus   (bus)
   );

   always #5 Clock = ~Clock;

   // Cycle index; read #1 after posedge by the driver and at negedge by the monitor.
   always @(posedge Clock) cyc <= cyc + 1;

   task automatic checkOutput(input string name, input int actual, input int expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0d expected %0d (cycle %0d)", name, actual, expected, cyc);
      end
   endtask

   task automatic reportFail(input string name);
      checks++;
      errors++;
      $display("[TB] FAIL %s: wait bound expired (cycle %0d)", name, cyc);
   endtask

   // Offer one job and play back the grant pattern. kinds: 0 done, 1 timeout, 2 abort.
   task automatic applyStimulus(input int len, input int dly, input int grantBeats,
                                input int hold, input bit noise);
      int   rStart;
      int   t;
      int   gHold;
      int   waitCnt;
      bit   gEn;
      bit   finished;
      exp_t e;

      waitCnt = 0;
      while (!bus.job_ready && waitCnt < 100) begin
         @(posedge Clock); #1;
         waitCnt++;
      end
      if (!bus.job_ready) begin
         reportFail("job_ready_wait");
         return;
      end

      bus.job_valid = 1'b1;
      bus.job_len   = LEN_W'(len);
      rStart        = cyc + 1;
      gHold         = 0;
      gEn           = (len != 0) && (dly < TIMEOUT);

      if (len == 0) begin
         e.kind = 0; e.beats = 0; e.cycle = rStart; e.rHigh = 0; e.relLen = GAP;
      end else if (dly >= TIMEOUT) begin
         e.kind = 1; e.beats = 0; e.cycle = rStart + TIMEOUT; e.rHigh = TIMEOUT; e.relLen = GAP;
      end else if (grantBeats >= len) begin
         gHold  = len + hold;
         e.kind = 0; e.beats = len; e.cycle = rStart + dly + len + 1;
         e.rHigh = dly + len + 1;
         e.relLen = (GAP > hold + 1) ? GAP : hold + 1;
      end else begin
         gHold  = grantBeats;
         e.kind = 2; e.beats = grantBeats; e.cycle = rStart + dly + grantBeats + 2;
         e.rHigh = dly + grantBeats + 2; e.relLen = GAP;
      end
      expQ.push_back(e);

      finished = 1'b0;
      for (int n = 0; n < 200 && !finished; n++) begin
         @(posedge Clock); #1;
         t = cyc - rStart;
         if (bus.job_ready) begin
            finished      = 1'b1;
            bus.job_valid = 1'b0;
            bus.g         = 1'b0;
         end else begin
            bus.job_valid = noise ? 1'($urandom_range(0, 1)) : 1'b0;
            bus.job_len   = LEN_W'($urandom_range(0, 15));
            bus.g         = gEn && (t >= dly) && (t <= dly + gHold);
         end
      end
      if (!finished) reportFail("job_end_wait");
   endtask

   // Monitor: per-cycle invariants, per-burst tallies, outcome scoreboard.
   always @(negedge Clock) begin
      int   nFlags;
      int   kind;
      exp_t e;
      if (!Resetn) begin
         rCount    = 0;
         xferCount = 0;
         inRelease = 1'b0;
      end else begin
         checkOutput("busy_vs_ready", int'(bus.busy), int'(!bus.job_ready));
         if (bus.r) rCount++;
         if (bus.xfer) begin
            checkOutput("beat_cnt_at_beat", int'(bus.beat_cnt), xferCount);
            xferCount++;
         end
         nFlags = int'(bus.done) + int'(bus.timeout_err) + int'(bus.abort_err);
         if (nFlags != 0) begin
            checkOutput("flags_exclusive", nFlags, 1);
            if (expQ.size() == 0) begin
               checks++;
               errors++;
               $display("[TB] FAIL unexpected_pulse: done=%0b timeout=%0b abort=%0b required none",
                        bus.done, bus.timeout_err, bus.abort_err);
            end else begin
               e    = expQ.pop_front();
               kind = bus.done ? 0 : (bus.timeout_err ? 1 : 2);
               checkOutput("outcome_kind", kind, e.kind);
               checkOutput("outcome_cycle", cyc, e.cycle);
               checkOutput("final_beat_cnt", int'(bus.beat_cnt), e.beats);
               checkOutput("xfer_count", xferCount, e.beats);
               checkOutput("r_high_cycles", rCount, e.rHigh);
               relExp    = e.relLen;
               relCount  = 0;
               inRelease = 1'b1;
            end
            rCount    = 0;
            xferCount = 0;
         end
         if (inRelease) begin
            if (bus.busy) begin
               relCount++;
            end else begin
               checkOutput("release_cycles", relCount, relExp);
               inRelease = 1'b0;
            end
         end
      end
   end

   // Directed cases, a randomized run, then reset in the middle of a burst.
   initial begin
      int rStart;
      int len;
      int mBeats;

      bus.job_valid = 1'b0;
      bus.job_len   = '0;
      bus.g         = 1'b0;
      Resetn        = 1'b0;
      repeat (3) @(posedge Clock);
      #1;
      checkOutput("reset_job_ready", int'(bus.job_ready), 1);
      checkOutput("reset_r", int'(bus.r), 0);
      checkOutput("reset_busy", int'(bus.busy), 0);
      checkOutput("reset_beat_cnt", int'(bus.beat_cnt), 0);
      checkOutput("reset_flags", int'({bus.done, bus.timeout_err, bus.abort_err}), 0);
      Resetn = 1'b1;
      @(posedge Clock); #1;

      applyStimulus(3, 1, 100, 0, 1'b0);
      applyStimulus(0, 1, 0, 0, 1'b0);
      applyStimulus(4, TIMEOUT, 0, 0, 1'b0);
      applyStimulus(5, 1, 2, 0, 1'b0);
      applyStimulus(2, 1, 100, 1, 1'b1);
      applyStimulus(2, 1, 100, 1, 1'b1);
      applyStimulus(6, TIMEOUT - 1, 100, 0, 1'b0);
      applyStimulus(15, 2, 100, 2, 1'b1);
      applyStimulus(3, 1, 0, 0, 1'b0);

      for (int j = 0; j < 40; j++) begin
         len    = $urandom_range(0, 15);
         mBeats = ($urandom_range(0, 3) == 0) ? $urandom_range(0, len) : len + 1;
         applyStimulus(len, $urandom_range(1, 20), mBeats, $urandom_range(0, 2),
                       1'($urandom_range(0, 1)));
      end

      repeat (3) @(negedge Clock);
      checkOutput("queue_drained", expQ.size(), 0);

      @(posedge Clock); #1;
      bus.job_valid = 1'b1;
      bus.job_len   = LEN_W'(8);
      rStart        = cyc + 1;
      for (int n = 0; n < 5; n++) begin
         @(posedge Clock); #1;
         bus.job_valid = 1'b0;
         bus.g         = ((cyc - rStart) >= 1);
      end
      checkOutput("mid_burst_xfer", int'(bus.xfer), 1);
      checkOutput("mid_burst_beat_cnt", int'(bus.beat_cnt), 2);
      Resetn = 1'b0;
      @(posedge Clock); #1;
      checkOutput("post_reset_r", int'(bus.r), 0);
      checkOutput("post_reset_beat_cnt", int'(bus.beat_cnt), 0);
      checkOutput("post_reset_flags", int'({bus.done, bus.timeout_err, bus.abort_err}), 0);
      bus.g  = 1'b0;
      Resetn = 1'b1;
      @(posedge Clock); #1;
      checkOutput("post_reset_job_ready", int'(bus.job_ready), 1);

      applyStimulus(2, 1, 100, 0, 1'b0);
      repeat (3) @(negedge Clock);
      checkOutput("final_queue_drained", expQ.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
